// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and pulse-shape the east/west/south buttons.
// Define BTN_AUTOREPEAT_EN to enable held-button auto-repeat of the step pulses.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 15000000,
   parameter int REPEAT_PERIOD   = 3000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_east,
   input  logic btn_west,
   input  logic btn_south,
   output logic east_level,
   output logic west_level,
   output logic south_level,
   output logic step_right,
   output logic step_left,
   output logic new_game
);
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20) || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("button_conditioner: parameter out of range");
   end
   localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
   logic [2:0] raw, s1, s2, lvl, lvl_nxt, rise;
   logic [19:0] cnt [3];
   logic [1:0] step;
   logic both, both_nxt;
   assign raw = {btn_south, btn_west, btn_east};
   always_comb begin
      for (int i = 0; i < 3; i++)
         lvl_nxt[i] = (s2[i] != lvl[i] && cnt[i] == DB_LAST) ? ~lvl[i] : lvl[i];
   end
   assign rise     = lvl_nxt & ~lvl;
   assign both     = lvl[0] & lvl[1];
   assign both_nxt = lvl_nxt[0] & lvl_nxt[1];
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         lvl <= '0;
         new_game <= 1'b0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         lvl <= lvl_nxt;
         new_game <= rise[2];
         for (int i = 0; i < 3; i++)
            cnt[i] <= (s2[i] == lvl[i] || cnt[i] == DB_LAST) ? '0 : cnt[i] + 20'd1;
      end
   end
`ifdef BTN_AUTOREPEAT_EN
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
   localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] RP_LAST = 32'(REPEAT_PERIOD - 1);
   state_t st [2];
   logic [31:0] t [2];
   always_ff @(posedge clk) begin
      if (reset) begin
         step <= '0;
         for (int d = 0; d < 2; d++) begin
            st[d] <= IDLE;
            t[d] <= '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            step[d] <= 1'b0;
            t[d] <= '0;
            if (both_nxt || !lvl_nxt[d]) st[d] <= IDLE;
            // the opposing button just let go: restart the hold delay silently
            else if (both) st[d] <= DELAY;
            else if (st[d] == IDLE) begin
               step[d] <= rise[d];
               st[d] <= rise[d] ? DELAY : IDLE;
            end else if (st[d] == DELAY) begin
               step[d] <= t[d] == RD_LAST;
               st[d] <= t[d] == RD_LAST ? REPEAT : DELAY;
               t[d] <= t[d] == RD_LAST ? '0 : t[d] + 32'd1;
            end else begin
               step[d] <= t[d] == RP_LAST;
               t[d] <= t[d] == RP_LAST ? '0 : t[d] + 32'd1;
            end
         end
      end
   end
`else
   always_ff @(posedge clk) step <= reset ? 2'b00 : rise[1:0] & {2{~both_nxt}};
`endif
   assign east_level  = lvl[0];
   assign west_level  = lvl[1];
   assign south_level = lvl[2];
   assign step_right  = step[0];
   assign step_left   = step[1];
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: randomized and directed stimulus scored against a behavioural button model.
module tb_button_conditioner;
   localparam int DB = 4, RD = 10, RP = 3;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1;
   logic btn_east = 1'b0, btn_west = 1'b0, btn_south = 1'b0;
   logic east_level, west_level, south_level, step_right, step_left, new_game;
   logic [5:0] exp_q [$];
   int checks = 0, errors = 0, cyc = 0;

   button_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
      .clk(clk), .reset(reset),
      .btn_east(btn_east), .btn_west(btn_west), .btn_south(btn_south),
      .east_level(east_level), .west_level(west_level), .south_level(south_level),
      .step_right(step_right), .step_left(step_left), .new_game(new_game)
   );

   always #5 clk = ~clk;

   // Reference model: a level follows the synchronised input once that input has
   // held a new value for DB consecutive samples; steps are scheduled by hold age.
   initial begin : model
      logic [2:0] s1, s2, lvl, prev, v, nl;
      logic [1:0] st, act;
      logic both_new;
      int run [3];
      int age [2];
      s1 = '0; s2 = '0; lvl = '0; prev = '0; act = '0;
      run = '{0, 0, 0};
      age = '{0, 0};
      forever begin
         @(posedge clk);
         if (reset) begin
            s1 = '0; s2 = '0; lvl = '0; prev = '0; act = '0;
            run = '{0, 0, 0};
            exp_q.push_back(6'b0);
         end else begin
            v = s2;
            nl = lvl;
            for (int i = 0; i < 3; i++) begin
               run[i] = (v[i] == prev[i]) ? run[i] + 1 : 1;
               if (v[i] != lvl[i] && run[i] >= DB) nl[i] = v[i];
            end
            prev = v;
            s2 = s1;
            s1 = {btn_south, btn_west, btn_east};
            both_new = nl[0] & nl[1];
            for (int d = 0; d < 2; d++) begin
               st[d] = 1'b0;
               if (!nl[d] || both_new) act[d] = 1'b0;
               else if (!act[d]) begin
                  act[d] = 1'b1;
                  age[d] = 0;
                  st[d] = ~lvl[d];
               end else begin
                  age[d]++;
                  st[d] = AUTO && age[d] >= RD && (age[d] - RD) % RP == 0;
               end
            end
            exp_q.push_back({nl[2] & ~lvl[2], st[1], st[0], nl[2], nl[1], nl[0]});
            lvl = nl;
         end
      end
   end

   initial begin : monitor
      logic [5:0] got, want;
      forever begin
         @(negedge clk);
         cyc++;
         got = {new_game, step_left, step_right, south_level, west_level, east_level};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty cycle=%0d actual=%b required=<queued entry>", cyc, got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL outputs cycle=%0d actual=%b required=%b (ng,sl,sr,s,w,e)", cyc, got, want);
            end
         end
      end
   end

   task automatic drive(input logic [2:0] b, input logic r, input int n);
      repeat (n) begin
         {btn_south, btn_west, btn_east} = b;
         reset = r;
         @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      drive(3'b111, 1'b1, 3);
      drive(3'b101, 1'b0, 20);
      drive(3'b000, 1'b0, 10);
      repeat (5) begin
         drive(3'b010, 1'b0, 3);
         drive(3'b000, 1'b0, 1);
      end
      drive(3'b010, 1'b0, 12);
      drive(3'b000, 1'b0, 10);
      drive(3'b001, 1'b0, 50);
      drive(3'b000, 1'b0, 10);
      drive(3'b001, 1'b0, 25);
      drive(3'b011, 1'b0, 15);
      drive(3'b001, 1'b0, 20);
      drive(3'b000, 1'b0, 10);
      drive(3'b001, 1'b0, 15);
      drive(3'b101, 1'b0, 20);
      drive(3'b001, 1'b0, 15);
      drive(3'b000, 1'b0, 10);
      drive(3'b001, 1'b0, 20);
      drive(3'b001, 1'b1, 2);
      drive(3'b001, 1'b0, 15);
      drive(3'b000, 1'b0, 10);
      for (int k = 0; k < 1500; k++) begin
         logic [2:0] b;
         b = {btn_south, btn_west, btn_east};
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 9) == 0) b[i] = ~b[i];
         drive(b, $urandom_range(0, 299) == 0, 1);
      end
      drive(3'b000, 1'b0, 12);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
